// File: rtl/squeeze_bias_relu.sv
// Post-MAC stage: adds sign-magnitude channel bias, applies ReLU and saturates
// to 16 bits, streaming results over a valid/ready handshake.
module squeeze_bias_relu #(
  parameter int NUM_CH     = 112,
  parameter int NUM_PIX    = 169,
  parameter int ACC_W      = 32,
  parameter int BIAS_SHIFT = 0,
  parameter int OUT_SHIFT  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_CH-1:0][15:0] bias_mem,
  input  logic signed [ACC_W-1:0] acc_data,
  input  logic                    acc_valid,
  output logic                    acc_ready,
  output logic [15:0]             out_data,
  output logic [6:0]              out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int CH_W  = (NUM_CH  > 1) ? $clog2(NUM_CH)  : 1;
  localparam int PIX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIX - 1);
  localparam logic signed [ACC_W:0] MAX_OUT = 32767;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [CH_W-1:0]         ch_cnt_q, ch_cnt_d;
  logic [PIX_W-1:0]        pix_cnt_q, pix_cnt_d;
  logic signed [ACC_W:0]   s1_sum_q, s1_sum_d;
  logic [CH_W-1:0]         s1_ch_q, s1_ch_d;
  logic                    s1_valid_q, s1_valid_d;
  logic [15:0]             out_data_q, out_data_d;
  logic [6:0]              out_ch_q, out_ch_d;
  logic                    out_valid_q, out_valid_d;

  logic                    adv, accept;
  logic [15:0]             bias_w;
  logic signed [15:0]      bias_mag, bias_tc;
  logic signed [ACC_W:0]   bias_ext, acc_ext, t;

  // One global enable: both stages move together or hold together.
  assign adv       = !out_valid_q || out_ready;
  assign acc_ready = (state_q == S_RUN) && adv;
  assign accept    = acc_valid && acc_ready;

  // Sign-magnitude to two's complement; 0x8000 maps to 0 naturally.
  assign bias_w   = bias_mem[ch_cnt_q];
  assign bias_mag = {1'b0, bias_w[14:0]};
  assign bias_tc  = bias_w[15] ? -bias_mag : bias_mag;
  assign bias_ext = {{(ACC_W-15){bias_tc[15]}}, bias_tc};
  assign acc_ext  = {acc_data[ACC_W-1], acc_data};
  assign t        = s1_sum_q >>> OUT_SHIFT;

  always_comb begin
    state_d     = state_q;
    ch_cnt_d    = ch_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    s1_sum_d    = s1_sum_q;
    s1_ch_d     = s1_ch_q;
    s1_valid_d  = s1_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_RUN;
        ch_cnt_d  = '0;
        pix_cnt_d = '0;
      end
      S_RUN: if (accept) begin
        if (ch_cnt_q == CH_LAST) begin
          ch_cnt_d  = '0;
          pix_cnt_d = pix_cnt_q + PIX_W'(1);
          if (pix_cnt_q == PIX_LAST) state_d = S_DRAIN;
        end else begin
          ch_cnt_d = ch_cnt_q + CH_W'(1);
        end
      end
      S_DRAIN: if (!s1_valid_q && !out_valid_q) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      s1_sum_d    = acc_ext + (bias_ext <<< BIAS_SHIFT);
      s1_ch_d     = ch_cnt_q;
      s1_valid_d  = accept;
      if (t[ACC_W])       out_data_d = 16'd0;
      else if (t > MAX_OUT) out_data_d = 16'd32767;
      else                out_data_d = t[15:0];
      out_ch_d    = 7'(s1_ch_q);
      out_valid_d = s1_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ch_cnt_q    <= '0;
      pix_cnt_q   <= '0;
      s1_sum_q    <= '0;
      s1_ch_q     <= '0;
      s1_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_cnt_q    <= ch_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      s1_sum_q    <= s1_sum_d;
      s1_ch_q     <= s1_ch_d;
      s1_valid_q  <= s1_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

endmodule
